led_bright_ctrl: RTL and testbench



---
 rtl/led_bright_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 71 +++++++
 rtl/led_bright_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_led_bright_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/led_bright_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_bright_pkg
// Description : Shared types and helpers for the LED brightness controller:
//               per-button repeat FSM state encoding and counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package led_bright_pkg;

    // Per-button repeat state machine, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESS  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPEAT = 2'd3
    } btn_state_e;

    // Width of a counter that runs 0..max_count-1 (never narrower than 1 bit)
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Active-low push-button front end: 2-flop synchroniser,
//               stability counter and registered press/release pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import led_bright_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int             CNT_W    = cnt_width(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept a new level only after DEBOUNCE_CYC consecutive differing samples
    always_comb begin
        level_d   = level_q;
        cnt_d     = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        press_d   = level_q & ~level_d;
        release_d = ~level_q & level_d;
    end

    // Synchroniser, debounced level and edge pulses; everything idles released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            level_q   <= 1'b1;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= btn_n;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign pressed       = ~level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule
`default_nettype wire

// File: rtl/led_bright_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_bright_ctrl
// Description : Brightness controller ahead of the PWM core. Two active-low
//               buttons drive a duty register with single steps and
//               hold-to-repeat. Optional macro LED_BRIGHT_WRAP_EN switches the
//               duty arithmetic from saturating to modulo 2^DUTY_W.
// Revision    : 1.0 - initial release
// ============================================================================
module led_bright_ctrl
    import led_bright_pkg::*;
#(
    parameter int DUTY_W        = 6,
    parameter int INIT_DUTY     = 32,
    parameter int STEP          = 4,
    parameter int DEBOUNCE_CYC  = 3,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up,
    input  logic              down,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_valid,
    output logic              at_max,
    output logic              at_min
);

    localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'((2 ** DUTY_W) - 1);
    localparam logic [DUTY_W-1:0] DUTY_INIT = DUTY_W'(INIT_DUTY);
    localparam int                HOLD_W    = cnt_width(REPEAT_DELAY);
    localparam int                REP_W     = cnt_width(REPEAT_PERIOD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_PERIOD - 1);

    // Index 0 is the up button, index 1 the down button
    logic [1:0] btn_n;
    logic [1:0] pressed;
    logic [1:0] step_ev;
    logic       both_pressed;

    assign btn_n        = {down, up};
    assign both_pressed = &pressed;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic              press_pulse;
            logic              release_pulse;
            btn_state_e        state_q, state_d;
            logic [HOLD_W-1:0] hold_q, hold_d;
            logic [REP_W-1:0]  rep_q, rep_d;
            logic              step;

            btn_debounce #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_debounce (
                .clk           (clk),
                .rst_n         (rst_n),
                .btn_n         (btn_n[gi]),
                .pressed       (pressed[gi]),
                .press_pulse   (press_pulse),
                .release_pulse (release_pulse)
            );

            // Repeat FSM: a chord parks both buttons in WAIT with a frozen hold count
            always_comb begin
                state_d = state_q;
                hold_d  = hold_q;
                rep_d   = rep_q;
                step    = 1'b0;
                if (both_pressed) begin
                    state_d = ST_WAIT;
                    hold_d  = '0;
                    rep_d   = '0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (press_pulse) state_d = ST_PRESS;
                        end
                        ST_PRESS: begin
                            step    = 1'b1;
                            hold_d  = '0;
                            state_d = release_pulse ? ST_IDLE : ST_WAIT;
                        end
                        ST_WAIT: begin
                            if (release_pulse) begin
                                state_d = ST_IDLE;
                            end else if (hold_q == HOLD_LAST) begin
                                step    = 1'b1;
                                rep_d   = '0;
                                state_d = ST_REPEAT;
                            end else begin
                                hold_d = hold_q + 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            if (release_pulse) begin
                                state_d = ST_IDLE;
                            end else if (rep_q == REP_LAST) begin
                                step  = 1'b1;
                                rep_d = '0;
                            end else begin
                                rep_d = rep_q + 1'b1;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end

            // FSM state and its hold/repeat counters
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= ST_IDLE;
                    hold_q  <= '0;
                    rep_q   <= '0;
                end else begin
                    state_q <= state_d;
                    hold_q  <= hold_d;
                    rep_q   <= rep_d;
                end
            end

            assign step_ev[gi] = step;
        end
    endgenerate

    logic              inc_ev;
    logic              dec_ev;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              duty_valid_q, duty_valid_d;

    assign inc_ev = step_ev[0] & ~step_ev[1];
    assign dec_ev = step_ev[1] & ~step_ev[0];

`ifdef LED_BRIGHT_WRAP_EN
    localparam logic [DUTY_W-1:0] STEP_N = DUTY_W'(STEP);

    // Modulo arithmetic: every accepted step is reported, even a full wrap
    always_comb begin
        duty_d       = duty_q;
        duty_valid_d = 1'b0;
        if (inc_ev) begin
            duty_d       = duty_q + STEP_N;
            duty_valid_d = 1'b1;
        end else if (dec_ev) begin
            duty_d       = duty_q - STEP_N;
            duty_valid_d = 1'b1;
        end
    end
`else
    localparam logic [DUTY_W:0] STEP_X = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W:0] MAX_X  = {1'b0, DUTY_MAX};

    logic [DUTY_W:0] sum_x;
    logic [DUTY_W:0] diff_x;

    // Saturating arithmetic one bit wider; a step that lands on the limit it
    // already sits at changes nothing and is not reported
    always_comb begin
        sum_x  = {1'b0, duty_q} + STEP_X;
        diff_x = {1'b0, duty_q} - STEP_X;
        duty_d = duty_q;
        if (inc_ev) begin
            duty_d = (sum_x > MAX_X) ? DUTY_MAX : sum_x[DUTY_W-1:0];
        end else if (dec_ev) begin
            duty_d = diff_x[DUTY_W] ? '0 : diff_x[DUTY_W-1:0];
        end
        duty_valid_d = (duty_d != duty_q);
    end
`endif

    // Duty register and its change strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q       <= DUTY_INIT;
            duty_valid_q <= 1'b0;
        end else begin
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
        end
    end

    assign duty       = duty_q;
    assign duty_valid = duty_valid_q;
    assign at_max     = (duty_q == DUTY_MAX);
    assign at_min     = (duty_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_led_bright_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_bright_ctrl
// Description : Directed bench for led_bright_ctrl (default saturating build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_bright_ctrl;

    logic       clk;
    logic       rst_n;
    logic       up;
    logic       down;
    logic [5:0] duty;
    logic       duty_valid;
    logic       at_max;
    logic       at_min;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulse = 0;
    int p0      = 0;

    led_bright_ctrl #(
        .DUTY_W        (6),
        .INIT_DUTY     (32),
        .STEP          (4),
        .DEBOUNCE_CYC  (3),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up         (up),
        .down       (down),
        .duty       (duty),
        .duty_valid (duty_valid),
        .at_max     (at_max),
        .at_min     (at_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // duty_valid lasts a whole cycle, so the falling edge sees each pulse once
    always @(negedge clk) if (duty_valid === 1'b1) n_pulse++;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        rst_n = 1'b0;
        up    = 1'b1;
        down  = 1'b1;
        tick(2);
        chk("rst_duty",   duty,       32);
        chk("rst_valid",  duty_valid, 0);
        chk("rst_at_max", at_max,     0);
        chk("rst_at_min", at_min,     0);
        rst_n = 1'b1;
        tick(2);

        // Clean 10-cycle press: one step, visible 6 cycles after the first low sample
        p0 = n_pulse;
        up = 1'b0;
        tick(6);
        chk("press_before_latency", duty, 32);
        tick(1);
        chk("press_duty",  duty,       36);
        chk("press_valid", duty_valid, 1);
        tick(1);
        chk("press_valid_drop", duty_valid, 0);
        tick(2);
        up = 1'b1;
        tick(10);
        chk("press_one_pulse", n_pulse - p0, 1);
        chk("press_final",     duty,         36);

        // 2-cycle glitch is filtered
        p0 = n_pulse;
        up = 1'b0;
        tick(2);
        up = 1'b1;
        tick(10);
        chk("glitch_pulses", n_pulse - p0, 0);
        chk("glitch_duty",   duty,         36);

        // Hold up, then reset mid-hold with the button still low
        reset_pulse();
        up = 1'b0;
        tick(26);
        chk("hold_before_repeat", duty, 36);
        tick(1);
        chk("hold_first_repeat", duty, 40);
        tick(3);
        chk("hold_mid", duty, 40);
        rst_n = 1'b0;
        #1;
        chk("async_reset_duty",  duty,       32);
        chk("async_reset_valid", duty_valid, 0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("repress_before", duty, 32);
        tick(1);
        chk("repress_after_reset", duty, 36);
        up = 1'b1;
        tick(10);

        // Hold down from 32 down to the floor
        reset_pulse();
        p0   = n_pulse;
        down = 1'b0;
        tick(26);
        chk("down_before_repeat", duty, 28);
        tick(1);
        chk("down_first_repeat", duty, 24);
        tick(30);
        chk("down_floor",        duty,       0);
        chk("down_at_min",       at_min,     1);
        chk("down_floor_valid",  duty_valid, 1);
        tick(5);
        chk("down_clamp_nopulse", duty_valid, 0);
        chk("down_clamp_duty",    duty,       0);
        tick(8);
        down = 1'b1;
        tick(10);
        chk("down_pulse_count", n_pulse - p0, 8);

        // Hold up from 0 to the ceiling
        up = 1'b0;
        tick(92);
        chk("up_at_60",     duty,   60);
        chk("up_60_no_max", at_max, 0);
        tick(5);
        chk("up_clamp_63", duty,       63);
        chk("up_at_max",   at_max,     1);
        chk("up_63_valid", duty_valid, 1);
        tick(5);
        chk("up_clamp_nopulse", duty_valid, 0);
        chk("up_clamp_duty",    duty,       63);
        up = 1'b1;
        tick(10);

        // Chord: up held, down added; release up and down resumes from WAIT
        reset_pulse();
        up = 1'b0;
        tick(7);
        chk("chord_first_up", duty, 36);
        tick(3);
        down = 1'b0;
        p0   = n_pulse;
        tick(50);
        chk("chord_hold_duty",   duty,         36);
        chk("chord_hold_pulses", n_pulse - p0, 0);
        up = 1'b1;
        tick(24);
        chk("chord_no_immediate", duty, 36);
        tick(1);
        chk("chord_down_step",  duty,       32);
        chk("chord_down_valid", duty_valid, 1);
        tick(5);
        chk("chord_down_repeat", duty, 28);
        down = 1'b1;
        tick(10);

        // Bouncy press and bouncy release produce exactly one step
        reset_pulse();
        p0 = n_pulse;
        for (int i = 0; i < 8; i++) begin
            up = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(1);
        end
        up = 1'b0;
        tick(10);
        chk("bounce_press_duty", duty, 36);
        for (int i = 0; i < 8; i++) begin
            up = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick(1);
        end
        up = 1'b1;
        tick(15);
        chk("bounce_pulses", n_pulse - p0, 1);
        chk("bounce_final",  duty,         36);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
